// File: rtl/lzx_rr_arbiter4.sv
// Four-way round-robin arbiter that drives the lzx_decoder2x4 select path, with a break-before-make release gap.
// Define LZX_ARB_TIMEOUT_EN to enable forced release after HOLD_MAX cycles of continuous grant.
module lzx_rr_arbiter4 #(
    parameter int HOLD_MAX = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       gnt_en,
    output logic [3:0] gnt_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       gnt_en_q, gnt_en_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [1:0] winner_s;
    logic [1:0] owner_s;
    logic       release_s;
    logic       forced_s;

    // First set request found scanning upward from p, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx   = p + k[1:0];
            pick  = (!found && r[idx]) ? idx : pick;
            found = found | r[idx];
        end
        return pick;
    endfunction

    assign winner_s  = rr_pick(req, ptr_q);
    assign owner_s   = {gnt_a_q, gnt_b_q};
    assign release_s = done | ~req[owner_s];

`ifdef LZX_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign forced_s = (cnt_q == CNT_LAST) & ~release_s;

    // Hold counter: cleared when a grant is issued, counts every GRANT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && (|req)) begin
            cnt_d = {CW{1'b0}};
        end else if (state_q == ST_GRANT) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign forced_s = 1'b0;
`endif

    // Next-state and registered-output logic for the grant sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_a_d   = gnt_a_q;
        gnt_b_d   = gnt_b_q;
        gnt_en_d  = gnt_en_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_a_d  = winner_s[1];
                    gnt_b_d  = winner_s[0];
                    gnt_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_GRANT;
                end else begin
                    gnt_en_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            ST_GRANT: begin
                // A normal release and a forced release share one path, so the pointer advances once.
                if (release_s || forced_s) begin
                    gnt_en_d  = 1'b0;
                    busy_d    = 1'b1;
                    ptr_d     = owner_s + 2'd1;
                    timeout_d = forced_s;
                    state_d   = ST_RELEASE;
                end else begin
                    gnt_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_RELEASE: begin
                gnt_en_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                gnt_en_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            gnt_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            gnt_en_q  <= gnt_en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Active-low one-hot decode of the registered select, all ones while disabled.
    always_comb begin
        gnt_n = 4'hF;
        if (gnt_en_q) begin
            gnt_n[{gnt_a_q, gnt_b_q}] = 1'b0;
        end else begin
            gnt_n = 4'hF;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign gnt_en  = gnt_en_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_lzx_rr_arbiter4.sv
// Self-checking bench for lzx_rr_arbiter4: directed scenarios plus randomized traffic against a behavioural model.
module tb_lzx_rr_arbiter4;

    localparam int HOLD = 8;
`ifdef LZX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       gnt_a;
    logic       gnt_b;
    logic       gnt_en;
    logic [3:0] gnt_n;
    logic       busy;
    logic       timeout;

    int pass_cnt;
    int total_cnt;

    lzx_rr_arbiter4 #(.HOLD_MAX(HOLD), .CW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .gnt_en  (gnt_en),
        .gnt_n   (gnt_n),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req   = 4'h0;
        done  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req   = 4'hF;
        done  = 1'b0;
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if (gnt_n !== 4'hF || gnt_en !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0)
            $display("FAIL reset_state got gnt_n=%b en=%b busy=%b to=%b a=%b b=%b want 1111 0 0 0 0 0",
                     gnt_n, gnt_en, busy, timeout, gnt_a, gnt_b);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (gnt_en !== 1'b1 || gnt_n !== 4'b1110 || busy !== 1'b1)
            $display("FAIL reset_first_grant got en=%b gnt_n=%b busy=%b want 1 1110 1", gnt_en, gnt_n, busy);
        else pass_cnt++;
    endtask

    task automatic test_single_grant();
        apply_reset();
        req = 4'b0100;
        tick();
        total_cnt++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || gnt_en !== 1'b1 || gnt_n !== 4'b1011)
            $display("FAIL single_grant got a=%b b=%b en=%b gnt_n=%b want 1 0 1 1011", gnt_a, gnt_b, gnt_en, gnt_n);
        else pass_cnt++;
        done = 1'b1;
        tick();
        done = 1'b0;
        total_cnt++;
        if (gnt_n !== 4'hF || busy !== 1'b1 || gnt_en !== 1'b0)
            $display("FAIL single_release got gnt_n=%b busy=%b en=%b want 1111 1 0", gnt_n, busy, gnt_en);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || gnt_en !== 1'b0)
            $display("FAIL single_idle got busy=%b en=%b want 0 0", busy, gnt_en);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b1110; exp_seq[1] = 4'b1101; exp_seq[2] = 4'b1011;
        exp_seq[3] = 4'b0111; exp_seq[4] = 4'b1110;
        apply_reset();
        req = 4'hF;
        tick();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (gnt_n !== exp_seq[i] || gnt_en !== 1'b1)
                $display("FAIL rotation_%0d got gnt_n=%b en=%b want %b 1", i, gnt_n, gnt_en, exp_seq[i]);
            else pass_cnt++;
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 4'b0100;
        tick();
        req  = 4'b0011;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (gnt_n !== 4'b1110 || gnt_en !== 1'b1 || gnt_a !== 1'b0 || gnt_b !== 1'b0)
            $display("FAIL wrap_grant got gnt_n=%b en=%b want 1110 1", gnt_n, gnt_en);
        else pass_cnt++;
    endtask

    task automatic test_withdraw();
        apply_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        total_cnt++;
        if (gnt_en !== 1'b0 || busy !== 1'b1 || gnt_n !== 4'hF)
            $display("FAIL withdraw_release got en=%b busy=%b gnt_n=%b want 0 1 1111", gnt_en, busy, gnt_n);
        else pass_cnt++;
        req = 4'hF;
        tick();
        tick();
        total_cnt++;
        if (gnt_n !== 4'b1011)
            $display("FAIL withdraw_ptr got gnt_n=%b want 1011", gnt_n);
        else pass_cnt++;
        req  = 4'b1011;
        done = 1'b1;
        tick();
        done = 1'b0;
        total_cnt++;
        if (gnt_en !== 1'b0 || busy !== 1'b1)
            $display("FAIL dual_release got en=%b busy=%b want 0 1", gnt_en, busy);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (gnt_n !== 4'b0111)
            $display("FAIL dual_single_advance got gnt_n=%b want 0111", gnt_n);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req = 4'b1000;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (gnt_n !== 4'hF || gnt_en !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0)
            $display("FAIL async_reset got gnt_n=%b en=%b busy=%b to=%b want 1111 0 0 0", gnt_n, gnt_en, busy, timeout);
        else pass_cnt++;
        req = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (gnt_n !== 4'b1110)
            $display("FAIL reset_ptr got gnt_n=%b want 1110", gnt_n);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int hi;
        int bad;
        logic to_seen;
        apply_reset();
        req = 4'b0010;
        tick();
        hi = 0;
        bad = 0;
        to_seen = 1'b0;
        if (TO_EN) begin
            for (int i = 0; i < 40; i++) begin
                if (gnt_en === 1'b1) begin
                    hi++;
                    if (timeout !== 1'b0) bad++;
                    tick();
                end else begin
                    to_seen = timeout;
                    break;
                end
            end
            total_cnt++;
            if (hi != HOLD || to_seen !== 1'b1 || bad != 0)
                $display("FAIL timeout_hold got cycles=%0d timeout=%b early=%0d want %0d 1 0", hi, to_seen, bad, HOLD);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (timeout !== 1'b0)
                $display("FAIL timeout_pulse_width got %b want 0", timeout);
            else pass_cnt++;
        end else begin
            for (int i = 0; i < 100; i++) begin
                if (gnt_en !== 1'b1 || timeout !== 1'b0) bad++;
                tick();
            end
            total_cnt++;
            if (bad != 0)
                $display("FAIL hold_forever got %0d bad cycles want 0", bad);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int m_owner;
        int m_last;
        int m_ptr;
        int m_hold;
        bit m_gap;
        bit m_to;
        bit rel;
        bit forced;
        bit exp_en;
        bit exp_busy;
        logic [3:0] exp_n;
        apply_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_gap = 1'b0; m_to = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 4) == 0);
            m_to = 1'b0;
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_owner < 0) begin
                if (req != 4'h0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (req[(m_ptr + k) % 4]) begin
                            m_owner = (m_ptr + k) % 4;
                            break;
                        end
                    end
                    m_last = m_owner;
                    m_hold = 0;
                end
            end else begin
                rel    = done || !req[m_owner];
                forced = TO_EN && (m_hold == HOLD - 1) && !rel;
                if (rel || forced) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                    m_gap   = 1'b1;
                    m_to    = forced;
                end else begin
                    m_hold++;
                end
            end
            tick();
            exp_en   = (m_owner >= 0);
            exp_busy = exp_en || m_gap;
            exp_n    = exp_en ? ~(4'b0001 << m_last) : 4'hF;
            total_cnt++;
            if (gnt_en !== exp_en || busy !== exp_busy || gnt_n !== exp_n ||
                {gnt_a, gnt_b} !== 2'(m_last) || timeout !== m_to)
                $display("FAIL random_cyc%0d got en=%b busy=%b gnt_n=%b idx=%0d to=%b want %b %b %b %0d %b",
                         cyc, gnt_en, busy, gnt_n, {gnt_a, gnt_b}, timeout,
                         exp_en, exp_busy, exp_n, m_last, m_to);
            else pass_cnt++;
        end
        req  = 4'h0;
        done = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        req   = 4'h0;
        done  = 1'b0;
        test_reset();
        test_single_grant();
        test_rotation();
        test_wrap();
        test_withdraw();
        test_reset_mid_grant();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
